// File: rtl/rs232_pkg.sv
// Shared definitions for the RS232 receive path: FSM state encoding, frame width,
// baud reload arithmetic and the parity helper.
package rs232_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } rx_state_e;

  localparam int DATA_BITS = 8;

  // Reload value that lands the first sample in the middle of the start bit.
  function automatic int half_reload(input int divisor);
    return divisor / 2 - 1;
  endfunction

  function automatic int full_reload(input int divisor);
    return divisor - 1;
  endfunction

  function automatic logic even_parity(input logic [DATA_BITS-1:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/rs232_baud_down_counter.sv
// Loadable baud down-counter; Z flags zero, so a reload on Z gives a period of K+1 cycles.
module rs232_baud_down_counter #(
  parameter int SIZE = 16
) (
  input  logic            CLK,
  input  logic            RESET,
  input  logic            load,
  input  logic [SIZE-1:0] K,
  output logic [SIZE-1:0] COUNTER,
  output logic            Z
);

  // Load or decrement; an unloaded counter wraps from 0 to all-ones.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      COUNTER <= {SIZE{1'b0}};
    end else if (load) begin
      COUNTER <= K;
    end else begin
      COUNTER <= COUNTER - {{(SIZE-1){1'b0}}, 1'b1};
    end
  end

  assign Z = (COUNTER == {SIZE{1'b0}});

endmodule

// File: rtl/rs232_rx_ctrl.sv
// RS232 receive sequencer: mid-bit sampling, byte assembly and VALID/RD_ACK handshake.
// Define RS232_RX_PARITY_EN for 8E1 framing with PARITY_ERR; otherwise 8N1.
module rs232_rx_ctrl
  import rs232_pkg::*;
#(
  parameter int SIZE    = 16,
  parameter int DIVISOR = 5208
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       RX,
  input  logic       RD_ACK,
  output logic [7:0] DATA,
  output logic       VALID,
  output logic       FRAME_ERR,
  output logic       OVERRUN,
  output logic       PARITY_ERR,
  output logic       BUSY
);

  localparam logic [SIZE-1:0] HALF = SIZE'(half_reload(DIVISOR));
  localparam logic [SIZE-1:0] FULL = SIZE'(full_reload(DIVISOR));

  logic [1:0]           sync_r;
  logic                 rx_s;
  logic                 load_s;
  logic [SIZE-1:0]      k_s;
  logic [SIZE-1:0]      counter_s;
  logic                 z_s;
  logic                 unused_s;
  rx_state_e            state_r;
  logic [2:0]           bit_cnt_r;
  logic [DATA_BITS-1:0] shift_reg_r;
`ifdef RS232_RX_PARITY_EN
  logic                 par_bad_r;
`endif

  // Two-flop synchronizer for the asynchronous RX pin, idling high.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      sync_r <= 2'b11;
    end else begin
      sync_r <= {sync_r[0], RX};
    end
  end

  assign rx_s = sync_r[1];

  // IDLE keeps the counter parked at HALF so the start edge launches the half-bit wait.
  always_comb begin
    load_s = 1'b0;
    k_s    = FULL;
    case (state_r)
      S_IDLE: begin
        load_s = 1'b1;
        k_s    = HALF;
      end
      default: begin
        load_s = z_s;
        k_s    = FULL;
      end
    endcase
  end

  rs232_baud_down_counter #(
    .SIZE(SIZE)
  ) u_baud (
    .CLK    (CLK),
    .RESET  (RESET),
    .load   (load_s),
    .K      (k_s),
    .COUNTER(counter_s),
    .Z      (z_s)
  );

  // The count value itself is only observed through Z.
  assign unused_s = ^counter_s;

  // Receive FSM with registered handshake outputs and single-cycle status pulses.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_r     <= S_IDLE;
      bit_cnt_r   <= 3'd0;
      shift_reg_r <= {DATA_BITS{1'b0}};
      DATA        <= 8'h00;
      VALID       <= 1'b0;
      FRAME_ERR   <= 1'b0;
      OVERRUN     <= 1'b0;
      PARITY_ERR  <= 1'b0;
      BUSY        <= 1'b0;
`ifdef RS232_RX_PARITY_EN
      par_bad_r   <= 1'b0;
`endif
    end else begin
      FRAME_ERR  <= 1'b0;
      OVERRUN    <= 1'b0;
      PARITY_ERR <= 1'b0;
      if (RD_ACK) begin
        VALID <= 1'b0;
      end else begin
        VALID <= VALID;
      end

      case (state_r)
        S_IDLE: begin
          if (!rx_s) begin
            state_r <= S_START;
            BUSY    <= 1'b1;
          end
        end
        S_START: begin
          if (z_s) begin
            if (!rx_s) begin
              state_r   <= S_DATA;
              bit_cnt_r <= 3'd0;
            end else begin
              state_r <= S_IDLE;
              BUSY    <= 1'b0;
            end
          end
        end
        S_DATA: begin
          if (z_s) begin
            shift_reg_r <= {rx_s, shift_reg_r[DATA_BITS-1:1]};
            bit_cnt_r   <= bit_cnt_r + 3'd1;
            if (bit_cnt_r == 3'(DATA_BITS - 1)) begin
`ifdef RS232_RX_PARITY_EN
              state_r <= S_PARITY;
`else
              state_r <= S_STOP;
`endif
            end
          end
        end
`ifdef RS232_RX_PARITY_EN
        S_PARITY: begin
          if (z_s) begin
            par_bad_r <= (rx_s != even_parity(shift_reg_r));
            state_r   <= S_STOP;
          end
        end
`endif
        S_STOP: begin
          if (z_s) begin
            state_r <= S_IDLE;
            BUSY    <= 1'b0;
            if (rx_s) begin
              DATA    <= shift_reg_r;
              VALID   <= 1'b1;
              // A same-cycle acknowledge frees the slot, so that is not an overrun.
              OVERRUN <= VALID & ~RD_ACK;
            end else begin
              FRAME_ERR <= 1'b1;
            end
`ifdef RS232_RX_PARITY_EN
            PARITY_ERR <= par_bad_r;
`endif
          end
        end
        default: begin
          state_r <= S_IDLE;
          BUSY    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rs232_rx_ctrl.sv
// Scoreboard bench for rs232_rx_ctrl: frame-level reference model, decoupled monitor and host.
module tb_rs232_rx_ctrl;

  localparam int DIV    = 16;
  localparam int HALF_T = DIV / 2 - 1;
`ifdef RS232_RX_PARITY_EN
  localparam int PAR_EN = 1;
`else
  localparam int PAR_EN = 0;
`endif
  localparam int NSLOT = 10 + PAR_EN;

  typedef struct {
    logic       fe;
    logic [7:0] data;
    logic       valid;
    logic       ovr;
    logic       per;
    int         cyc;
  } item_t;

  logic       CLK = 1'b0;
  logic       RESET = 1'b1;
  logic       RX = 1'b1;
  logic       RD_ACK = 1'b0;
  logic [7:0] DATA;
  logic       VALID, FRAME_ERR, OVERRUN, PARITY_ERR, BUSY;

  int         checks = 0;
  int         errors = 0;
  int         cyc = 0;
  item_t      sbq[$];
  logic       auto_ack = 1'b1;
  logic       pending = 1'b0;
  logic [7:0] model_data = 8'h00;

  rs232_rx_ctrl #(.SIZE(16), .DIVISOR(DIV)) dut (
    .CLK(CLK), .RESET(RESET), .RX(RX), .RD_ACK(RD_ACK), .DATA(DATA), .VALID(VALID),
    .FRAME_ERR(FRAME_ERR), .OVERRUN(OVERRUN), .PARITY_ERR(PARITY_ERR), .BUSY(BUSY)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge CLK); #1; end
  endtask

  // Sends one frame starting now; abort_slot >= 0 pulses RESET mid-way through that slot.
  task automatic send_frame(input logic [7:0] d, input logic stop, input logic par_ok,
                            input int abort_slot);
    logic [10:0] bits;
    item_t it;
    int s;
    bits = 11'h7FF;
    bits[0] = 1'b0;
    for (int i = 0; i < 8; i++) bits[1+i] = d[i];
    if (PAR_EN == 1) bits[9] = (^d) ^ ~par_ok;
    bits[NSLOT-1] = stop;
    s = cyc;
    if (abort_slot < 0) begin
      it.fe    = ~stop;
      it.per   = (PAR_EN == 1) && !par_ok;
      it.data  = stop ? d : model_data;
      it.valid = stop ? 1'b1 : pending;
      it.ovr   = stop && pending;
      // 2 sync stages + FSM sees it at t0 = s+3, then 1 + HALF + (bits after start)*DIV.
      it.cyc   = s + 3 + 1 + HALF_T + (NSLOT - 1) * DIV;
      if (stop) begin
        model_data = d;
        pending    = ~auto_ack;
      end
      sbq.push_back(it);
    end
    for (int i = 0; i < NSLOT; i++) begin
      RX = bits[i];
      if (i == abort_slot) begin
        idle(8);
        chk("busy_mid_frame", BUSY, 1'b1);
        RESET = 1'b1;
        idle(1);
        RESET = 1'b0;
        RX = 1'b1;
        chk("reset_busy", BUSY, 1'b0);
        chk("reset_valid", VALID, 1'b0);
        chk("reset_data", DATA, 8'h00);
        pending    = 1'b0;
        model_data = 8'h00;
        return;
      end
      idle(DIV);
    end
    RX = 1'b1;
  endtask

  task automatic drain();
    int i;
    i = 0;
    while (sbq.size() != 0 && i < 400) begin idle(1); i++; end
    chk("scoreboard_drain", sbq.size(), 0);
    sbq.delete();
  endtask

  task automatic wait_valid_low();
    int i;
    i = 0;
    while (VALID && i < 100) begin idle(1); i++; end
    chk("valid_low_wait", VALID, 1'b0);
  endtask

  // Monitor: every delivered byte or framing error is matched against the scoreboard.
  initial begin
    logic valid_prev, pulse_prev, ev_del, ev_fe;
    item_t it;
    valid_prev = 1'b0;
    pulse_prev = 1'b0;
    forever begin
      @(negedge CLK);
      ev_del = (VALID && !valid_prev) || OVERRUN;
      ev_fe  = FRAME_ERR;
      if (ev_del || ev_fe) begin
        chk("event_expected", sbq.size() != 0, 1'b1);
        if (sbq.size() != 0) begin
          it = sbq.pop_front();
          chk("event_kind_frame_err", ev_fe, it.fe);
          chk("event_cycle", cyc, it.cyc);
          chk("data", DATA, it.data);
          chk("valid", VALID, it.valid);
          chk("overrun", OVERRUN, it.ovr);
          chk("parity_err", PARITY_ERR, it.per);
        end
      end else if (PARITY_ERR !== 1'b0) begin
        chk("stray_parity_err", PARITY_ERR, 1'b0);
      end
      if (pulse_prev) chk("pulse_width", {FRAME_ERR, OVERRUN, PARITY_ERR}, 3'b000);
      pulse_prev = FRAME_ERR | OVERRUN | PARITY_ERR;
      valid_prev = VALID;
    end
  end

  // Host: when enabled, acknowledges a waiting byte after a random delay.
  initial begin
    int dly;
    forever begin
      @(negedge CLK);
      if (auto_ack && VALID === 1'b1) begin
        dly = $urandom_range(0, 10);
        repeat (dly) @(negedge CLK);
        @(posedge CLK); #1 RD_ACK = 1'b1;
        @(posedge CLK); #1 RD_ACK = 1'b0;
        @(negedge CLK);
        chk("valid_clear_after_ack", VALID, 1'b0);
      end
    end
  end

  initial begin
    logic [7:0] d;
    logic stop, par_ok;
    int s;
    RESET = 1'b1;
    idle(3);
    chk("rst_data", DATA, 8'h00);
    chk("rst_valid", VALID, 1'b0);
    chk("rst_busy", BUSY, 1'b0);
    chk("rst_pulses", {FRAME_ERR, OVERRUN, PARITY_ERR}, 3'b000);
    RESET = 1'b0;
    idle(4);

    send_frame(8'h55, 1'b1, 1'b1, -1);
    idle(16);
    drain();

    // Start glitch: 4 low cycles must be rejected at the half-bit sample.
    s = cyc;
    RX = 1'b0;
    idle(4);
    chk("glitch_busy_start", BUSY, 1'b1);
    RX = 1'b1;
    idle(s + 12 - cyc);
    chk("glitch_busy_idle", BUSY, 1'b0);
    chk("glitch_valid", VALID, 1'b0);
    idle(16);

    send_frame(8'hA3, 1'b0, 1'b1, -1);
    idle(20);
    drain();

    send_frame(8'h00, 1'b1, 1'b1, -1);
    idle(16);
    send_frame(8'hFF, 1'b1, 1'b1, -1);
    idle(16);
    for (int n = 0; n < 20; n++) begin
      d      = 8'($urandom_range(0, 255));
      stop   = ($urandom_range(0, 7) != 0);
      par_ok = ($urandom_range(0, 3) != 0);
      send_frame(d, stop, par_ok, -1);
      idle($urandom_range(16, 24));
      drain();
    end

`ifdef RS232_RX_PARITY_EN
    send_frame(8'h07, 1'b1, 1'b0, -1);
    idle(16);
    drain();
    send_frame(8'h07, 1'b1, 1'b1, -1);
    idle(16);
    drain();
`endif

    wait_valid_low();
    idle(4);
    auto_ack = 1'b0;
    send_frame(8'h12, 1'b1, 1'b1, -1);
    send_frame(8'h34, 1'b1, 1'b1, -1);
    idle(4);
    drain();
    chk("overrun_hold_valid", VALID, 1'b1);
    chk("overrun_hold_data", DATA, 8'h34);

    d = 8'($urandom_range(0, 255));
    send_frame(d, 1'b1, 1'b1, 5);
    idle(8);
    auto_ack = 1'b1;
    send_frame(8'h0F, 1'b1, 1'b1, -1);
    idle(16);
    drain();
    wait_valid_low();
    idle(4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/rs232_rx_ctrl.md
# rs232_rx_ctrl

Receive-side sequencer for the RS232 peripheral. Drives the loadable baud down-counter and places each sample point at the middle of a bit: half a bit period after the start edge, then one full period per bit. Each sample is shifted into a byte register, and the block presents the byte to the host through a level-valid/acknowledge handshake. It sits between the asynchronous RX pin and the peripheral's register interface.

## Interface
- SIZE, 16: width of the baud counter and of its reload value.
- DIVISOR, 5208: clock cycles per bit (50 MHz / 9600 baud). Legal range is 4 to 2^SIZE−1. Simulation uses 16.
- CLK  in  1  system clock; all logic on the rising edge.
- RESET  in  1  synchronous, active-high reset.
- RX  in  1  asynchronous serial line; idle level is 1.
- RD_ACK  in  1  host has consumed DATA; clears VALID.
- DATA  out  8  last received byte, LSB first on the wire.
- VALID  out  1  level; a byte is waiting in DATA.
- FRAME_ERR  out  1  one-cycle pulse; the stop bit sampled as 0.
- OVERRUN  out  1  one-cycle pulse; a byte completed while VALID was already 1.
- PARITY_ERR  out  1  one-cycle pulse; only meaningful with the parity build (see Configuration).
- BUSY  out  1  high in every state except IDLE.

## Operation
- RX passes through a 2-FF synchronizer; the result is rx_s. The FSM sees only rx_s.
- Baud counter behaviour:
  - load=1 sets the counter to K.
  - load=0 decrements it; it wraps from 0 to all-ones if left unloaded.
  - Z=1 when the counter is 0.
  - A load issued in the cycle Z is seen gives a period of K+1 cycles.
- Reload values:
  - HALF = DIVISOR/2 − 1 (integer division).
  - FULL = DIVISOR − 1.
  - Both are computed at elaboration, SIZE bits wide.
- States and transitions:
  - IDLE: load=1 with HALF. If rx_s==0, go to START.
  - START: when Z, sample rx_s. If 0, load FULL, clear bit_cnt, go to DATA. If 1 (glitch), go to IDLE with no outputs.
  - DATA: when Z, shift_reg <= {rx_s, shift_reg[7:1]} and load FULL. bit_cnt goes 0→7. At bit_cnt==7, go to PARITY (parity build) or STOP.
  - PARITY: when Z, compare rx_s with the expected parity bit, load FULL, go to STOP.
  - STOP: when Z, sample rx_s and go to IDLE.
    - Sample 1: DATA <= shift_reg, VALID <= 1, and OVERRUN pulses if VALID was already 1.
    - Sample 0: FRAME_ERR pulses; DATA and VALID are unchanged.
- While not Z, the FSM holds load=0. The counter and FSM always advance together.
- Handshake:
  - VALID stays 1 until the cycle after RD_ACK=1.
  - If RD_ACK and a new byte completion fall in the same cycle, VALID stays 1, DATA takes the new byte, and OVERRUN is not raised.
  - RD_ACK while VALID=0 is ignored.
- RESET:
  - Returns the FSM to IDLE mid-frame, discards the partial byte, and does not pulse any flag.
  - Reset values: DATA=0x00, VALID=0, FRAME_ERR=0, OVERRUN=0, PARITY_ERR=0, BUSY=0, counter=0, bit_cnt=0, both synchronizer flops=1.

## Timing
- Let t0 be the first CLK edge at which rx_s==0. The FSM is in START from t0+1.
- The start-bit sample is taken at t0+1+HALF. The data-bit samples follow every DIVISOR cycles.
- The stop bit is sampled at t0+1+HALF+9·DIVISOR, or +10·DIVISOR with parity.
- VALID, FRAME_ERR and OVERRUN register on the edge after the stop sample; the pulses are exactly one cycle wide.
- Pin-to-rx_s latency is 2 cycles.
- The FSM is back in IDLE mid-stop-bit. A start edge arriving immediately after the stop bit is still caught.

## Configuration
- RS232_RX_PARITY_EN defined:
  - The PARITY state is added.
  - Even parity: expected bit = ^shift_reg.
  - A mismatch pulses PARITY_ERR on the same edge as the stop-bit result. The byte is still delivered.
- RS232_RX_PARITY_EN undefined:
  - 8N1 framing; there is no PARITY state.
  - PARITY_ERR is tied to 0.

## Structure
- Shared package rs232_pkg holds:
  - the state encoding constants (IDLE=0, START=1, DATA=2, PARITY=3, STOP=4, 3 bits);
  - DATA_BITS=8;
  - the HALF/FULL reload calculation.
- The counter is a separate sub-module, rs232_baud_down_counter: SIZE parameter, ports CLK, RESET, load, K, COUNTER, Z, synchronous reset. This block instantiates it once.

## Test plan
- DIVISOR=16, frame 0x55 8N1 → start sample at t0+8, DATA=0x55, VALID=1 on the edge after stop sample; RD_ACK for 1 cycle → VALID=0.
- RX low for 4 cycles, then high → FSM back in IDLE at t0+8; no VALID/FRAME_ERR pulse; BUSY=0.
- Frame 0xA3 with stop bit 0 → FRAME_ERR one-cycle pulse, VALID stays 0, DATA unchanged.
- Two back-to-back frames 0x12, 0x34 with no RD_ACK → second completion pulses OVERRUN, DATA=0x34, VALID=1.
- RESET asserted during bit 4 of a frame → next edge: IDLE, BUSY=0, VALID=0, DATA=0x00; next clean frame 0x0F received correctly.
- RS232_RX_PARITY_EN, frame 0x07 with parity bit 0 → PARITY_ERR pulse, DATA=0x07, VALID=1; parity bit 1 → no PARITY_ERR.
